pio_key_irq: RTL and testbench

- Parametrised Avalon-MM input PIO for board push-buttons and switches.
- Per channel: 2-FF synchroniser, debounce filter, edge-capture register, interrupt mask and a level interrupt to the Nios II.
- Next generation of the fixed 4-bit read-only key PIO. Generalised in width, debounce time, edge sense and idle level; adds write access and an interrupt.

---
 rtl/pio_key_irq_if.sv | 22 ++
 rtl/pio_key_irq.sv | 132 +++++++++++++
 tb/tb_pio_key_irq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_key_irq_if.sv
// Avalon-MM bus bundle for the key PIO: word address, single-cycle write
// strobe, 32-bit write data and registered 32-bit read data.
interface pio_key_irq_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_key_irq.sv
// Parametrised input PIO for push-buttons and switches. Each channel is
// synchronised, debounced, edge-captured and masked into one level interrupt.
// Register map: 0 DATA (debounced), 1 RAW (synchronised), 2 IRQMASK (R/W),
// 3 EDGECAP (write-1-to-clear). Reads are registered (latency 1).
module pio_key_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_key_irq_if.slave     bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int                        CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]             CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]             CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]             CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]          ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]          IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0][CW-1:0]  CNT_CLR  = {(WIDTH * CW){1'b0}};

  logic [WIDTH-1:0]          sync1_q;
  logic [WIDTH-1:0]          sync2_q;
  logic [WIDTH-1:0]          db_q;
  logic [WIDTH-1:0]          db_d;
  logic [WIDTH-1:0][CW-1:0]  cnt_q;
  logic [WIDTH-1:0][CW-1:0]  cnt_d;
  logic [WIDTH-1:0]          edge_q;
  logic [WIDTH-1:0]          edge_d;
  logic [WIDTH-1:0]          mask_q;
  logic [WIDTH-1:0]          mask_d;
  logic [31:0]               rdata_q;
  logic [31:0]               rdata_d;

  logic [WIDTH-1:0]          rise_s;
  logic [WIDTH-1:0]          fall_s;
  logic [WIDTH-1:0]          cap_s;
  logic [WIDTH-1:0]          clr_s;
  logic                      wr_mask_s;
  logic                      wr_edge_s;
  logic                      wdata_unused_s;

  // Bits of writedata above WIDTH carry no meaning for this block.
  assign wdata_unused_s = ^bus.writedata;

  // Per-channel debounce: a change is accepted only after DEBOUNCE_CYCLES stable clocks.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge detection on the accepted debounced flip, filtered by the configured sense.
  always_comb begin
    rise_s = db_d & ~db_q;
    fall_s = db_q & ~db_d;
    if (EDGE_TYPE == 0) begin
      cap_s = rise_s;
    end else if (EDGE_TYPE == 1) begin
      cap_s = fall_s;
    end else begin
      cap_s = rise_s | fall_s;
    end
  end

  // Register writes: mask load and W1C on edge capture; a new edge beats a clear.
  always_comb begin
    wr_mask_s = bus.write && (bus.address == 2'd2);
    wr_edge_s = bus.write && (bus.address == 2'd3);
    if (wr_mask_s) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_edge_s) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = ZERO_W;
    end
    edge_d = (edge_q & ~clr_s) | cap_s;
  end

  // Read mux, sampled into readdata every clock; upper bits stay zero.
  always_comb begin
    rdata_d = 32'h0000_0000;
    case (bus.address)
      2'd0:    rdata_d[WIDTH-1:0] = db_q;
      2'd1:    rdata_d[WIDTH-1:0] = sync2_q;
      2'd2:    rdata_d[WIDTH-1:0] = mask_q;
      2'd3:    rdata_d[WIDTH-1:0] = edge_q;
      default: rdata_d = 32'h0000_0000;
    endcase
  end

  // State registers; reset parks inputs at the idle level so no edge appears on exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_VEC;
      sync2_q <= IDLE_VEC;
      db_q    <= IDLE_VEC;
      cnt_q   <= CNT_CLR;
      edge_q  <= ZERO_W;
      mask_q  <= ZERO_W;
      rdata_q <= 32'h0000_0000;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_key_irq.sv
// Self-checking bench for pio_key_irq: three configurations run side by side
// against a sliding-window reference model, plus a register-access vector
// table and hand-written multi-cycle sequences.
module tb_pio_key_irq;

  localparam int NI = 3;
  localparam int P_W    [NI] = '{4, 32, 8};
  localparam int P_D    [NI] = '{4, 1, 3};
  localparam int P_E    [NI] = '{1, 2, 0};
  localparam int P_IDLE [NI] = '{1, 0, 0};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [31:0] inp    [NI];
  logic [1:0]  addr   [NI];
  logic        wr     [NI];
  logic [31:0] wd     [NI];
  logic [31:0] dut_rd [NI];
  logic        dut_irq[NI];
  logic        irq0, irq1, irq2;

  pio_key_irq_if bus0 ();
  pio_key_irq_if bus1 ();
  pio_key_irq_if bus2 ();

  assign bus0.address = addr[0];
  assign bus0.write = wr[0];
  assign bus0.writedata = wd[0];
  assign bus1.address = addr[1];
  assign bus1.write = wr[1];
  assign bus1.writedata = wd[1];
  assign bus2.address = addr[2];
  assign bus2.write = wr[2];
  assign bus2.writedata = wd[2];

  always_comb begin
    dut_rd[0]  = bus0.readdata;
    dut_rd[1]  = bus1.readdata;
    dut_rd[2]  = bus2.readdata;
    dut_irq[0] = irq0;
    dut_irq[1] = irq1;
    dut_irq[2] = irq2;
  end

  pio_key_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(inp[0][3:0]), .irq(irq0));
  pio_key_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(2), .IDLE_LEVEL(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(inp[1]), .irq(irq1));
  pio_key_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(0), .IDLE_LEVEL(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(inp[2][7:0]), .irq(irq2));

  // Reference model: history of sampled inputs; a debounced bit flips when the
  // D samples that reached sync2 most recently all disagree with it.
  logic [31:0] hist   [NI][6];
  logic [31:0] m_db   [NI];
  logic [31:0] m_edge [NI];
  logic [31:0] m_mask [NI];
  logic [31:0] m_rd   [NI];
  logic        m_irq  [NI];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] wmask(int n);
    return (P_W[n] == 32) ? 32'hFFFF_FFFF : ((32'h1 << P_W[n]) - 32'h1);
  endfunction

  function automatic logic [31:0] idle_vec(int n);
    return (P_IDLE[n] != 0) ? wmask(n) : 32'h0;
  endfunction

  task automatic model_reset(int n);
    for (int j = 0; j < 6; j++) hist[n][j] = idle_vec(n);
    m_db[n]   = idle_vec(n);
    m_edge[n] = 32'h0;
    m_mask[n] = 32'h0;
    m_rd[n]   = 32'h0;
    m_irq[n]  = 1'b0;
  endtask

  task automatic model_edge(int n);
    logic [31:0] wm, all1, all0, flip, ndb, cap, clr;
    int d;
    wm = wmask(n);
    d  = P_D[n];
    for (int j = 0; j <= d; j++) hist[n][j] = hist[n][j + 1];
    hist[n][d + 1] = inp[n] & wm;
    case (addr[n])
      2'd0:    m_rd[n] = m_db[n];
      2'd1:    m_rd[n] = hist[n][d - 1];
      2'd2:    m_rd[n] = m_mask[n];
      default: m_rd[n] = m_edge[n];
    endcase
    all1 = wm;
    all0 = wm;
    for (int j = 0; j < d; j++) begin
      all1 = all1 & hist[n][j];
      all0 = all0 & ~hist[n][j];
    end
    flip = (m_db[n] & all0) | (~m_db[n] & all1 & wm);
    ndb  = m_db[n] ^ flip;
    case (P_E[n])
      0:       cap = flip & ndb;
      1:       cap = flip & ~ndb;
      default: cap = flip;
    endcase
    clr = (wr[n] && addr[n] == 2'd3) ? (wd[n] & wm) : 32'h0;
    m_edge[n] = (m_edge[n] & ~clr) | cap;
    if (wr[n] && addr[n] == 2'd2) m_mask[n] = wd[n] & wm;
    m_db[n]  = ndb;
    m_irq[n] = |(m_edge[n] & m_mask[n]);
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs in force, then compare all DUTs.
  task automatic tick();
    @(posedge clk);
    for (int n = 0; n < NI; n++) begin
      if (!reset_n) model_reset(n);
      else model_edge(n);
    end
    #1;
    for (int n = 0; n < NI; n++) begin
      check($sformatf("model_rd%0d", n), dut_rd[n], m_rd[n]);
      check($sformatf("model_irq%0d", n), {31'h0, dut_irq[n]}, {31'h0, m_irq[n]});
    end
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic bus_op(int n, logic [1:0] a, logic w, logic [31:0] d);
    addr[n] = a;
    wr[n]   = w;
    wd[n]   = d;
    tick();
    wr[n]   = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{2'd2, 1'b1, 32'h0000_0001, 32'h0, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 32'h0000_0000, 32'h1, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 32'hFFFF_FFF5, 32'h1, 1'b0};
    vecs[3] = '{2'd2, 1'b0, 32'h0000_0000, 32'h5, 1'b0};
    vecs[4] = '{2'd2, 1'b1, 32'h0000_0001, 32'h5, 1'b0};
    vecs[5] = '{2'd0, 1'b0, 32'h0000_0000, 32'hF, 1'b0};
    vecs[6] = '{2'd1, 1'b0, 32'h0000_0000, 32'hF, 1'b0};
    vecs[7] = '{2'd3, 1'b1, 32'h0000_000F, 32'h0, 1'b0};
    vecs[8] = '{2'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b0};
    vecs[9] = '{2'd2, 1'b0, 32'h0000_0000, 32'h1, 1'b0};

    reset_n = 1'b0;
    inp[0] = 32'hF;
    inp[1] = 32'h0;
    inp[2] = 32'h0;
    for (int n = 0; n < NI; n++) begin
      addr[n] = 2'd0;
      wr[n]   = 1'b0;
      wd[n]   = 32'h0;
      model_reset(n);
    end

    // Reset state and idle after release.
    ticks(3);
    check("reset_rd", dut_rd[0], 32'h0);
    check("reset_irq", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;
    ticks(100);
    check("idle_data", dut_rd[0], 32'hF);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("idle_edgecap", dut_rd[0], 32'h0);
    check("idle_irq", {31'h0, irq0}, 32'h0);

    // Register access table on instance 0.
    for (int v = 0; v < 10; v++) begin
      bus_op(0, vecs[v].addr, vecs[v].wr, vecs[v].wd);
      check($sformatf("vec%0d_rd", v), dut_rd[0], vecs[v].exp_rd);
      check($sformatf("vec%0d_irq", v), {31'h0, irq0}, {31'h0, vecs[v].exp_irq});
    end

    // Glitch of 3 clocks on bit 2 is rejected.
    addr[0] = 2'd0;
    inp[0]  = 32'hB;
    ticks(3);
    inp[0]  = 32'hF;
    ticks(10);
    check("glitch_data", dut_rd[0], 32'hF);
    check("glitch_irq", {31'h0, irq0}, 32'h0);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("glitch_edgecap", dut_rd[0], 32'h0);

    // Press bit 0: irq rises exactly on the 6th edge after the change.
    addr[0] = 2'd0;
    inp[0]  = 32'hE;
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("press_irq_e%0d", j), {31'h0, irq0}, (j == 5) ? 32'h1 : 32'h0);
    end
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("press_edgecap", dut_rd[0], 32'h1);
    bus_op(0, 2'd0, 1'b0, 32'h0);
    check("press_data", dut_rd[0], 32'hE);

    // Clear race: W1C on the same edge that accepts a new falling edge.
    inp[0] = 32'hF;
    ticks(8);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("release_edgecap", dut_rd[0], 32'h1);
    inp[0] = 32'hE;
    ticks(5);
    bus_op(0, 2'd3, 1'b1, 32'h1);
    check("race_irq", {31'h0, irq0}, 32'h1);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("race_edgecap", dut_rd[0], 32'h1);
    bus_op(0, 2'd3, 1'b1, 32'h1);
    check("clear_irq", {31'h0, irq0}, 32'h0);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("clear_edgecap", dut_rd[0], 32'h0);

    // Mask: bit 3 captured while masked, irq follows the mask write.
    bus_op(0, 2'd2, 1'b1, 32'h0);
    inp[0] = 32'h6;
    ticks(6);
    check("masked_irq", {31'h0, irq0}, 32'h0);
    bus_op(0, 2'd3, 1'b0, 32'h0);
    check("masked_edgecap", dut_rd[0], 32'h8);
    bus_op(0, 2'd2, 1'b1, 32'h8);
    check("unmask_irq", {31'h0, irq0}, 32'h1);

    // Any-edge mode on the 32-bit instance, bit 31.
    addr[1] = 2'd0;
    inp[1]  = 32'h8000_0000;
    ticks(3);
    bus_op(1, 2'd0, 1'b0, 32'h0);
    check("any_rise_data", dut_rd[1], 32'h8000_0000);
    bus_op(1, 2'd3, 1'b0, 32'h0);
    check("any_rise_edgecap", dut_rd[1], 32'h8000_0000);
    bus_op(1, 2'd3, 1'b1, 32'h8000_0000);
    inp[1] = 32'h0;
    ticks(3);
    bus_op(1, 2'd0, 1'b0, 32'h0);
    check("any_fall_data", dut_rd[1], 32'h0);
    bus_op(1, 2'd3, 1'b0, 32'h0);
    check("any_fall_edgecap", dut_rd[1], 32'h8000_0000);
    bus_op(1, 2'd3, 1'b1, 32'hFFFF_FFFF);
    addr[1] = 2'd1;
    inp[1]  = 32'hA5A5_5A5A;
    ticks(3);
    check("raw_track", dut_rd[1], 32'hA5A5_5A5A);

    // Randomised traffic: bouncing inputs and random bus operations on every instance.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < NI; n++) begin
        if ($urandom_range(0, 5) == 0)
          inp[n] = (inp[n] ^ (32'h1 << $urandom_range(0, P_W[n] - 1))) & wmask(n);
        addr[n] = 2'($urandom_range(0, 3));
        wr[n]   = ($urandom_range(0, 5) == 0);
        wd[n]   = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
